// File: rtl/stream_prefetch_buffer.sv
// stream_prefetch_buffer: fully-associative line prefetch buffer between the upstream requester and pmem.
// Optional hit/issue counters are built when PREFETCH_STATS_EN is defined.
module stream_prefetch_buffer #(
    parameter int ENTRIES = 4,
    parameter int QDEPTH  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  address,
    input  logic         read,
    input  logic         write,
    input  logic [255:0] wdata,
    output logic [255:0] rdata,
    output logic         resp,
    input  logic [31:0]  ORB,
    input  logic         prefetch_en,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_issued
);
    localparam int EW = $clog2(ENTRIES);
    localparam int QW = $clog2(QDEPTH);

    typedef enum logic [2:0] {IDLE, HIT_RESP, DMD_RD, DMD_WR, PF_RD, RESP} state_t;

    state_t             state_q;
    logic [ENTRIES-1:0] valid_q;
    logic [26:0]        etag_q [ENTRIES];
    logic [255:0]       line_q [ENTRIES];
    logic [EW-1:0]      ptr_q;
    logic [26:0]        qtag_q [QDEPTH];
    logic [QDEPTH-1:0]  qlive_q;
    logic [QW-1:0]      qhead_q, qhead_d, qtail;
    logic [QW:0]        qcnt_q, qcnt_d;
    logic [26:0]        pf_tag_q;
    logic [255:0]       rdata_q, pmem_wdata_q;
    logic [31:0]        pmem_address_q;
    logic               resp_q, pmem_read_q, pmem_write_q;

    logic [26:0]   tag, orb_tag;
    logic          hit, orb_dup, idle, pop, pf_go, push, drop, pf_match;
    logic [EW-1:0] hit_idx;
    logic          unused_ok;

    assign tag       = address[31:5];
    assign orb_tag   = ORB[31:5];
    assign unused_ok = ^{address[4:0], ORB[4:0]};

    assign rdata        = rdata_q;
    assign resp         = resp_q;
    assign pmem_address = pmem_address_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_wdata   = pmem_wdata_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        orb_dup = (state_q == PF_RD) && (pf_tag_q == orb_tag);
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && etag_q[i] == tag) begin
                hit     = 1'b1;
                hit_idx = EW'(i);
            end
            if (valid_q[i] && etag_q[i] == orb_tag) orb_dup = 1'b1;
        end
        for (int i = 0; i < QDEPTH; i++)
            if (qlive_q[i] && qtag_q[i] == orb_tag) orb_dup = 1'b1;
    end

    // A full queue with no pop discards its oldest slot; the tail then lands on the old head.
    assign idle     = state_q == IDLE;
    assign pop      = idle && !write && !read && qcnt_q != '0;
    assign pf_go    = pop && qlive_q[qhead_q];
    assign push     = prefetch_en && !orb_dup;
    assign drop     = push && !pop && qcnt_q == (QW+1)'(QDEPTH);
    assign qtail    = qhead_q + qcnt_q[QW-1:0];
    assign qhead_d  = qhead_q + QW'(pop || drop);
    assign qcnt_d   = qcnt_q + (QW+1)'(push) - (QW+1)'(pop || drop);
    assign pf_match = tag == pf_tag_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            ptr_q          <= '0;
            qlive_q        <= '0;
            qhead_q        <= '0;
            qcnt_q         <= '0;
            pf_tag_q       <= '0;
            rdata_q        <= '0;
            resp_q         <= 1'b0;
            pmem_address_q <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_wdata_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                etag_q[i] <= '0;
                line_q[i] <= '0;
            end
            for (int i = 0; i < QDEPTH; i++) qtag_q[i] <= '0;
        end else begin
            qhead_q <= qhead_d;
            qcnt_q  <= qcnt_d;
            if (pop || drop) qlive_q[qhead_q] <= 1'b0;
            if (idle && write)
                for (int i = 0; i < QDEPTH; i++)
                    if (qtag_q[i] == tag) qlive_q[i] <= 1'b0;
            if (push) begin
                qtag_q[qtail]  <= orb_tag;
                qlive_q[qtail] <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (write) begin
                        for (int i = 0; i < ENTRIES; i++)
                            if (etag_q[i] == tag) valid_q[i] <= 1'b0;
                        pmem_address_q <= {tag, 5'b0};
                        pmem_wdata_q   <= wdata;
                        pmem_write_q   <= 1'b1;
                        state_q        <= DMD_WR;
                    end else if (read && hit) begin
                        rdata_q <= line_q[hit_idx];
                        resp_q  <= 1'b1;
                        state_q <= HIT_RESP;
                    end else if (read) begin
                        pmem_address_q <= {tag, 5'b0};
                        pmem_read_q    <= 1'b1;
                        state_q        <= DMD_RD;
                    end else if (pf_go) begin
                        pf_tag_q       <= qtag_q[qhead_q];
                        pmem_address_q <= {qtag_q[qhead_q], 5'b0};
                        pmem_read_q    <= 1'b1;
                        state_q        <= PF_RD;
                    end
                end
                DMD_RD, DMD_WR: begin
                    if (pmem_resp) begin
                        if (state_q == DMD_RD) rdata_q <= pmem_rdata;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        resp_q       <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                PF_RD: begin
                    if (pmem_resp) begin
                        pmem_read_q <= 1'b0;
                        state_q     <= IDLE;
                        if (!(write && pf_match)) begin
                            line_q[ptr_q]  <= pmem_rdata;
                            etag_q[ptr_q]  <= pf_tag_q;
                            valid_q[ptr_q] <= 1'b1;
                            ptr_q          <= ptr_q + EW'(1);
                            if (read && pf_match) begin
                                rdata_q <= pmem_rdata;
                                resp_q  <= 1'b1;
                                state_q <= RESP;
                            end
                        end
                    end
                end
                default: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] hits_q, issued_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hits_q   <= '0;
            issued_q <= '0;
        end else begin
            if (idle && !write && read && hit && hits_q != '1) hits_q <= hits_q + 32'd1;
            if (pf_go && issued_q != '1) issued_q <= issued_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_issued = issued_q;
`else
    assign stat_hits   = '0;
    assign stat_issued = '0;
`endif
endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// tb_stream_prefetch_buffer: directed scenarios for stream_prefetch_buffer against a simple pmem responder.
module tb_stream_prefetch_buffer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  address = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [255:0] wdata = '0;
    logic [255:0] rdata;
    logic         resp;
    logic [31:0]  ORB = '0;
    logic         prefetch_en = 1'b0;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [31:0]  stat_hits;
    logic [31:0]  stat_issued;

`ifdef PREFETCH_STATS_EN
    localparam logic [31:0] ONE_IF_STATS = 32'd1;
`else
    localparam logic [31:0] ONE_IF_STATS = 32'd0;
`endif
    localparam logic [255:0] L_AA = {32{8'hAA}};
    localparam logic [255:0] L_55 = {32{8'h55}};
    localparam logic [255:0] L_33 = {32{8'h33}};
    localparam logic [255:0] L_CC = {32{8'hCC}};
    localparam logic [255:0] L_77 = {32{8'h77}};
    localparam logic [255:0] L_66 = {32{8'h66}};

    int           n_checks = 0;
    int           n_pass = 0;
    int           rd_count = 0;
    int           wr_count = 0;
    int           mem_delay = 2;
    int           mem_cnt = 0;
    bit           mem_hold = 1'b0;
    bit           mem_prev = 1'b0;
    logic [31:0]  rd_log [64];
    logic [31:0]  wr_addr = '0;
    logic [255:0] wr_data = '0;
    logic [255:0] mem_data = '0;

    always #5 clk = ~clk;

    stream_prefetch_buffer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .wdata(wdata), .rdata(rdata), .resp(resp), .ORB(ORB), .prefetch_en(prefetch_en),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .stat_hits(stat_hits), .stat_issued(stat_issued)
    );

    // Logs each new pmem request and answers it mem_delay negedges later unless held.
    always @(negedge clk) begin
        if (!reset_n) begin
            pmem_resp = 1'b0;
            mem_cnt   = 0;
            mem_prev  = 1'b0;
        end else begin
            if ((pmem_read || pmem_write) && !mem_prev) begin
                if (pmem_read) begin
                    rd_log[rd_count & 63] = pmem_address;
                    rd_count++;
                end else begin
                    wr_addr = pmem_address;
                    wr_data = pmem_wdata;
                    wr_count++;
                end
            end
            mem_prev = pmem_read || pmem_write;
            if (pmem_resp) pmem_resp = 1'b0;
            else if (mem_prev && !mem_hold) begin
                if (mem_cnt == mem_delay) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_data;
                    mem_cnt    = 0;
                end else mem_cnt++;
            end
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_pf(input logic [31:0] a);
        ORB = a;
        prefetch_en = 1'b1;
        @(negedge clk);
        prefetch_en = 1'b0;
    endtask

    task automatic poll_rd(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (rd_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                          output logic [255:0] d, output int lat, output logic after);
        address = a;
        wdata = wd;
        read = !wr;
        write = wr;
        lat = -1;
        d = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (resp) begin
                lat = i;
                d = rdata;
                break;
            end
        end
        @(negedge clk);
        after = resp;
        read = 1'b0;
        write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (resp !== 1'b0) $display("FAIL reset_resp got %b exp 0", resp); else n_pass++;
        n_checks++; if (rdata !== '0) $display("FAIL reset_rdata got %h exp 0", rdata); else n_pass++;
        n_checks++; if (pmem_read !== 1'b0) $display("FAIL reset_pmem_read got %b exp 0", pmem_read); else n_pass++;
        n_checks++; if (pmem_write !== 1'b0) $display("FAIL reset_pmem_write got %b exp 0", pmem_write); else n_pass++;
        n_checks++; if (pmem_address !== '0) $display("FAIL reset_pmem_address got %h exp 0", pmem_address); else n_pass++;
        n_checks++; if (pmem_wdata !== '0) $display("FAIL reset_pmem_wdata got %h exp 0", pmem_wdata); else n_pass++;
        n_checks++; if (stat_hits !== '0) $display("FAIL reset_stat_hits got %0d exp 0", stat_hits); else n_pass++;
        n_checks++; if (stat_issued !== '0) $display("FAIL reset_stat_issued got %0d exp 0", stat_issued); else n_pass++;
    endtask

    task automatic test_prefetch_hit();
        int s, lat;
        bit ok;
        logic after;
        logic [255:0] d;
        mem_data = L_AA;
        s = rd_count;
        pulse_pf(32'h0000_1040);
        poll_rd(s + 1, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL pf_issue got %b exp 1", ok); else n_pass++;
        n_checks++; if (rd_log[s] !== 32'h0000_1040) $display("FAIL pf_addr got %h exp 00001040", rd_log[s]); else n_pass++;
        repeat (6) @(negedge clk);
        s = rd_count;
        do_req(1'b0, 32'h0000_1044, '0, d, lat, after);
        n_checks++; if (lat !== 1) $display("FAIL hit_latency got %0d exp 1", lat); else n_pass++;
        n_checks++; if (d !== L_AA) $display("FAIL hit_rdata got %h exp %h", d, L_AA); else n_pass++;
        n_checks++; if (after !== 1'b0) $display("FAIL hit_resp_width got %b exp 0", after); else n_pass++;
        n_checks++; if (rd_count !== s) $display("FAIL hit_no_pmem got %0d exp %0d", rd_count, s); else n_pass++;
        n_checks++; if (stat_hits !== ONE_IF_STATS) $display("FAIL stat_hits got %0d exp %0d", stat_hits, ONE_IF_STATS); else n_pass++;
        n_checks++; if (stat_issued !== ONE_IF_STATS) $display("FAIL stat_issued got %0d exp %0d", stat_issued, ONE_IF_STATS); else n_pass++;
    endtask

    task automatic test_demand_miss();
        int s, lat;
        logic after;
        logic [255:0] d;
        mem_data = L_55;
        s = rd_count;
        do_req(1'b0, 32'h0000_2000, '0, d, lat, after);
        n_checks++; if (lat !== 4) $display("FAIL miss_latency got %0d exp 4", lat); else n_pass++;
        n_checks++; if (d !== L_55) $display("FAIL miss_rdata got %h exp %h", d, L_55); else n_pass++;
        n_checks++; if (rd_log[s] !== 32'h0000_2000) $display("FAIL miss_addr got %h exp 00002000", rd_log[s]); else n_pass++;
        n_checks++; if (after !== 1'b0) $display("FAIL miss_resp_width got %b exp 0", after); else n_pass++;
        do_req(1'b0, 32'h0000_2010, '0, d, lat, after);
        n_checks++; if (rd_count !== s + 2) $display("FAIL miss_again got %0d exp %0d", rd_count, s + 2); else n_pass++;
        n_checks++; if (rd_log[s+1] !== 32'h0000_2000) $display("FAIL miss_aligned got %h exp 00002000", rd_log[s+1]); else n_pass++;
        n_checks++; if (d !== L_55) $display("FAIL miss_again_rdata got %h exp %h", d, L_55); else n_pass++;
    endtask

    task automatic test_write_inval();
        int s, w, lat;
        bit ok;
        logic after;
        logic [255:0] d;
        mem_data = L_33;
        s = rd_count;
        pulse_pf(32'h0000_3000);
        poll_rd(s + 1, ok);
        repeat (6) @(negedge clk);
        w = wr_count;
        do_req(1'b1, 32'h0000_3000, L_CC, d, lat, after);
        n_checks++; if (lat !== 4) $display("FAIL wr_latency got %0d exp 4", lat); else n_pass++;
        n_checks++; if (wr_count !== w + 1) $display("FAIL wr_once got %0d exp %0d", wr_count, w + 1); else n_pass++;
        n_checks++; if (wr_addr !== 32'h0000_3000) $display("FAIL wr_addr got %h exp 00003000", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== L_CC) $display("FAIL wr_data got %h exp %h", wr_data, L_CC); else n_pass++;
        s = rd_count;
        do_req(1'b0, 32'h0000_3000, '0, d, lat, after);
        n_checks++; if (rd_count !== s + 1) $display("FAIL inval_miss got %0d exp %0d", rd_count, s + 1); else n_pass++;
        n_checks++; if (lat !== 4) $display("FAIL inval_latency got %0d exp 4", lat); else n_pass++;
    endtask

    task automatic test_inflight();
        int s, lat;
        bit ok;
        logic after;
        logic [255:0] d;
        mem_data = L_77;
        mem_delay = 6;
        s = rd_count;
        pulse_pf(32'h0000_4000);
        poll_rd(s + 1, ok);
        do_req(1'b0, 32'h0000_4000, '0, d, lat, after);
        mem_delay = 2;
        n_checks++; if (lat !== 7) $display("FAIL merge_latency got %0d exp 7", lat); else n_pass++;
        n_checks++; if (d !== L_77) $display("FAIL merge_rdata got %h exp %h", d, L_77); else n_pass++;
        n_checks++; if (rd_count !== s + 1) $display("FAIL merge_single_rd got %0d exp %0d", rd_count, s + 1); else n_pass++;
        do_req(1'b0, 32'h0000_4000, '0, d, lat, after);
        n_checks++; if (lat !== 1) $display("FAIL merge_installed got %0d exp 1", lat); else n_pass++;
        n_checks++; if (d !== L_77) $display("FAIL merge_hit_rdata got %h exp %h", d, L_77); else n_pass++;
    endtask

    task automatic test_queue();
        int s, lat;
        bit ok1, ok2;
        logic after;
        logic [255:0] d;
        mem_data = L_55;
        mem_hold = 1'b1;
        s = rd_count;
        fork
            do_req(1'b0, 32'h0000_5000, '0, d, lat, after);
            begin
                poll_rd(s + 1, ok1);
                pulse_pf(32'h0000_0100);
                pulse_pf(32'h0000_0200);
                pulse_pf(32'h0000_0200);
                pulse_pf(32'h0000_0300);
                mem_hold = 1'b0;
            end
        join
        n_checks++; if ((lat > 0) !== 1'b1) $display("FAIL q_demand_done got %0d exp >0", lat); else n_pass++;
        poll_rd(s + 3, ok2);
        repeat (20) @(negedge clk);
        n_checks++; if (rd_log[s] !== 32'h0000_5000) $display("FAIL q_demand_addr got %h exp 00005000", rd_log[s]); else n_pass++;
        n_checks++; if (rd_log[s+1] !== 32'h0000_0200) $display("FAIL q_first got %h exp 00000200", rd_log[s+1]); else n_pass++;
        n_checks++; if (rd_log[s+2] !== 32'h0000_0300) $display("FAIL q_second got %h exp 00000300", rd_log[s+2]); else n_pass++;
        n_checks++; if (rd_count !== s + 3) $display("FAIL q_total got %0d exp %0d", rd_count, s + 3); else n_pass++;
    endtask

    task automatic test_wrap_reset();
        int s, lat, good;
        bit ok;
        logic after;
        logic [255:0] d;
        apply_reset();
        mem_data = L_66;
        good = 0;
        for (int i = 0; i < 5; i++) begin
            s = rd_count;
            pulse_pf(32'h0000_6000 + 32'(i) * 32'h20);
            poll_rd(s + 1, ok);
            if (ok) good++;
            repeat (6) @(negedge clk);
        end
        n_checks++; if (good !== 5) $display("FAIL wrap_fills got %0d exp 5", good); else n_pass++;
        s = rd_count;
        do_req(1'b0, 32'h0000_6000, '0, d, lat, after);
        n_checks++; if (lat !== 4) $display("FAIL wrap_evicted_latency got %0d exp 4", lat); else n_pass++;
        n_checks++; if (rd_count !== s + 1) $display("FAIL wrap_evicted_rd got %0d exp %0d", rd_count, s + 1); else n_pass++;
        do_req(1'b0, 32'h0000_6020, '0, d, lat, after);
        n_checks++; if (lat !== 1) $display("FAIL wrap_second_hit got %0d exp 1", lat); else n_pass++;
        do_req(1'b0, 32'h0000_6080, '0, d, lat, after);
        n_checks++; if (lat !== 1) $display("FAIL wrap_fifth_hit got %0d exp 1", lat); else n_pass++;
        n_checks++; if (d !== L_66) $display("FAIL wrap_rdata got %h exp %h", d, L_66); else n_pass++;
        mem_hold = 1'b1;
        s = rd_count;
        pulse_pf(32'h0000_7000);
        poll_rd(s + 1, ok);
        n_checks++; if (pmem_read !== 1'b1) $display("FAIL pf_inflight got %b exp 1", pmem_read); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (pmem_read !== 1'b0) $display("FAIL async_reset_rd got %b exp 0", pmem_read); else n_pass++;
        n_checks++; if (stat_hits !== '0) $display("FAIL async_reset_hits got %0d exp 0", stat_hits); else n_pass++;
        n_checks++; if (pmem_address !== '0) $display("FAIL async_reset_addr got %h exp 0", pmem_address); else n_pass++;
        repeat (2) @(negedge clk);
        mem_hold = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        s = rd_count;
        do_req(1'b0, 32'h0000_6080, '0, d, lat, after);
        n_checks++; if (lat !== 4) $display("FAIL reset_cleared_latency got %0d exp 4", lat); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (rd_count !== s + 1) $display("FAIL reset_cleared_rd got %0d exp %0d", rd_count, s + 1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_prefetch_hit();
        test_demand_miss();
        test_write_inval();
        test_inflight();
        test_queue();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
